sram_banked_mp: RTL and testbench



---
 rtl/sram_banked_mp.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sram_banked_mp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_banked_mp.sv
// Word-interleaved multi-port banked SRAM: per-bank round-robin arbitration,
// per-port grant/rvalid handshake, configurable read latency.
module sram_banked_mp #(
    parameter int NumPorts  = 2,
    parameter int NumBanks  = 4,
    parameter int NumWords  = 1024,
    parameter int DataWidth = 64,
    parameter int UserWidth = 1,
    parameter bit UserEn    = 1'b0,
    parameter int Latency   = 1,
    localparam int AddrW    = $clog2(NumWords),
    localparam int BankW    = $clog2(NumBanks),
    localparam int BeW      = (DataWidth + 7) / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumPorts-1:0]           req_i,
    output logic [NumPorts-1:0]           gnt_o,
    input  logic [NumPorts-1:0]           we_i,
    input  logic [NumPorts*AddrW-1:0]     addr_i,
    input  logic [NumPorts*DataWidth-1:0] wdata_i,
    input  logic [NumPorts*BeW-1:0]       be_i,
    input  logic [NumPorts*UserWidth-1:0] wuser_i,
    output logic [NumPorts-1:0]           rvalid_o,
    output logic [NumPorts*DataWidth-1:0] rdata_o,
    output logic [NumPorts*UserWidth-1:0] ruser_o
);

    localparam int BkW   = (BankW > 0) ? BankW : 1;
    localparam int RowW  = AddrW - BankW;
    localparam int Rows  = NumWords / NumBanks;
    localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [NumPorts-1:0][AddrW-1:0]     port_addr;
    logic [NumPorts-1:0][BkW-1:0]       port_bank;
    logic [NumPorts-1:0][RowW-1:0]      port_row;
    logic [NumBanks-1:0][NumPorts-1:0]  bank_req;
    logic [NumBanks-1:0][NumPorts-1:0]  bank_gnt;
    logic [NumBanks-1:0][PortW-1:0]     bank_sel;
    logic [NumBanks-1:0]                bank_act;
    logic [NumBanks-1:0][PortW-1:0]     rr_d, rr_q;
    logic [NumBanks-1:0]                bank_we;
    logic [NumBanks-1:0][RowW-1:0]      bank_row;
    logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;
    logic [NumBanks-1:0][DataWidth-1:0] bank_bmask;
    logic [NumBanks-1:0][BeW-1:0]       bank_be;
    logic [NumBanks-1:0][UserWidth-1:0] bank_wuser;
    logic [NumBanks-1:0][DataWidth-1:0] bank_rdata;
    logic [NumBanks-1:0][UserWidth-1:0] bank_ruser;

    logic [NumPorts-1:0]                s0_vld_d, s0_vld_q;
    logic [NumPorts-1:0]                s0_rd_d, s0_rd_q;
    logic [NumPorts-1:0][BkW-1:0]       s0_bank_d, s0_bank_q;
    logic [NumPorts-1:0][DataWidth-1:0] s0_rdata;
    logic [NumPorts-1:0][UserWidth-1:0] s0_ruser;

    // Low address bits select the bank, the rest select the row.
    always_comb begin
        port_addr = '0;
        port_bank = '0;
        port_row  = '0;
        bank_req  = '0;
        for (int p = 0; p < NumPorts; p++) begin
            port_addr[p] = addr_i[p*AddrW +: AddrW];
            port_bank[p] = BkW'(port_addr[p] & AddrW'(NumBanks - 1));
            port_row[p]  = RowW'(port_addr[p] >> BankW);
        end
        for (int b = 0; b < NumBanks; b++) begin
            for (int p = 0; p < NumPorts; p++) begin
                bank_req[b][p] = req_i[p] && (port_bank[p] == BkW'(b));
            end
        end
    end

    always_comb begin
        int idx;
        bank_gnt = '0;
        bank_sel = '0;
        bank_act = '0;
        rr_d     = rr_q;
        idx      = 0;
        for (int b = 0; b < NumBanks; b++) begin
            for (int off = 0; off < NumPorts; off++) begin
                idx = (int'(rr_q[b]) + off) % NumPorts;
                if (!bank_act[b] && bank_req[b][idx]) begin
                    bank_act[b]      = 1'b1;
                    bank_sel[b]      = PortW'(idx);
                    bank_gnt[b][idx] = 1'b1;
                end
            end
            if (bank_act[b]) begin
                rr_d[b] = (bank_sel[b] == PortW'(NumPorts - 1)) ?
                          '0 : bank_sel[b] + PortW'(1);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NumBanks; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    always_comb begin
        int s;
        bank_we    = '0;
        bank_row   = '0;
        bank_wdata = '0;
        bank_be    = '0;
        bank_wuser = '0;
        bank_bmask = '0;
        s          = 0;
        for (int b = 0; b < NumBanks; b++) begin
            s             = int'(bank_sel[b]);
            bank_we[b]    = we_i[s];
            bank_row[b]   = port_row[s];
            bank_wdata[b] = wdata_i[s*DataWidth +: DataWidth];
            bank_be[b]    = be_i[s*BeW +: BeW];
            bank_wuser[b] = wuser_i[s*UserWidth +: UserWidth];
            for (int i = 0; i < DataWidth; i++) begin
                bank_bmask[b][i] = bank_be[b][i/8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [DataWidth-1:0] mem [Rows];
        logic [DataWidth-1:0] rdata_q;

        always_ff @(posedge clk_i) begin
            if (bank_act[b]) begin
                if (bank_we[b]) begin
                    mem[bank_row[b]] <= (mem[bank_row[b]] & ~bank_bmask[b])
                                      | (bank_wdata[b] & bank_bmask[b]);
                end else begin
                    rdata_q <= mem[bank_row[b]];
                end
            end
        end
        assign bank_rdata[b] = rdata_q;

        if (UserEn) begin : g_user
            logic [UserWidth-1:0] umem [Rows];
            logic [UserWidth-1:0] ruser_q;

            always_ff @(posedge clk_i) begin
                if (bank_act[b]) begin
                    if (bank_we[b] && |bank_be[b]) begin
                        umem[bank_row[b]] <= bank_wuser[b];
                    end else if (!bank_we[b]) begin
                        ruser_q <= umem[bank_row[b]];
                    end
                end
            end
            assign bank_ruser[b] = ruser_q;
        end else begin : g_nouser
            logic unused_wuser;
            assign unused_wuser  = ^bank_wuser[b];
            assign bank_ruser[b] = '0;
        end
    end

    // First response stage sits beside the array read; data gated to 0 unless a read.
    always_comb begin
        s0_vld_d  = gnt_o;
        s0_rd_d   = gnt_o & ~we_i;
        s0_bank_d = port_bank;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_vld_q  <= '0;
            s0_rd_q   <= '0;
            s0_bank_q <= '0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_rd_q   <= s0_rd_d;
            s0_bank_q <= s0_bank_d;
        end
    end

    always_comb begin
        s0_rdata = '0;
        s0_ruser = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (s0_rd_q[p]) begin
                s0_rdata[p] = bank_rdata[s0_bank_q[p]];
                s0_ruser[p] = bank_ruser[s0_bank_q[p]];
            end
        end
    end

    if (Latency == 1) begin : g_lat1
        assign rvalid_o = s0_vld_q;
        assign rdata_o  = s0_rdata;
        assign ruser_o  = s0_ruser;
    end else begin : g_pipe
        localparam int Depth = Latency - 1;
        logic [NumPorts-1:0]           pv_d [Depth];
        logic [NumPorts-1:0]           pv_q [Depth];
        logic [NumPorts*DataWidth-1:0] pd_d [Depth];
        logic [NumPorts*DataWidth-1:0] pd_q [Depth];
        logic [NumPorts*UserWidth-1:0] pu_d [Depth];
        logic [NumPorts*UserWidth-1:0] pu_q [Depth];

        always_comb begin
            pv_d[0] = s0_vld_q;
            pd_d[0] = s0_rdata;
            pu_d[0] = s0_ruser;
            for (int i = 1; i < Depth; i++) begin
                pv_d[i] = pv_q[i-1];
                pd_d[i] = pd_q[i-1];
                pu_d[i] = pu_q[i-1];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < Depth; i++) begin
                    pv_q[i] <= '0;
                    pd_q[i] <= '0;
                    pu_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < Depth; i++) begin
                    pv_q[i] <= pv_d[i];
                    pd_q[i] <= pd_d[i];
                    pu_q[i] <= pu_d[i];
                end
            end
        end

        assign rvalid_o = pv_q[Depth-1];
        assign rdata_o  = pd_q[Depth-1];
        assign ruser_o  = pu_q[Depth-1];
    end

    if (Latency < 1) begin : g_bad_lat
        $error("Latency must be >= 1");
    end
    if (NumWords % NumBanks != 0) begin : g_bad_words
        $error("NumWords must be a multiple of NumBanks");
    end
    if ((1 << BankW) != NumBanks) begin : g_bad_banks
        $error("NumBanks must be a power of 2");
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            $onehot0(bank_gnt[b]));
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (gnt_o & ~req_i) == '0);

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown(req_i));

endmodule

// File: tb/tb_sram_banked_mp.sv
// Directed bench: one Latency=1 and one Latency=3 instance share the inputs.
module tb_sram_banked_mp;
  localparam int NP = 2;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req, we, wuser;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP*BW-1:0] be;
  logic [NP-1:0]    gnt1, gnt3, rv1, rv3, ru1, ru3;
  logic [NP*DW-1:0] rd1, rd3;

  int n_cmp = 0;
  int n_err = 0;

  sram_banked_mp #(
    .NumPorts(2), .NumBanks(4), .NumWords(1024),
    .DataWidth(64), .UserWidth(1), .UserEn(1'b0), .Latency(1)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1),
    .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .wuser_i(wuser), .rvalid_o(rv1), .rdata_o(rd1), .ruser_o(ru1)
  );

  sram_banked_mp #(
    .NumPorts(2), .NumBanks(4), .NumWords(1024),
    .DataWidth(64), .UserWidth(1), .UserEn(1'b0), .Latency(3)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt3),
    .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .wuser_i(wuser), .rvalid_o(rv3), .rdata_o(rd3), .ruser_o(ru3)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0;
    we  = '0;
  endtask

  task automatic setp(input int p, input logic w,
                      input logic [AW-1:0] a,
                      input logic [63:0] d,
                      input logic [7:0] b);
    req[p]            = 1'b1;
    we[p]             = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
    be[p*BW +: BW]    = b;
    wuser[p]          = 1'b1;
  endtask

  // One lone request on dut1: expect same-cycle grant, response next cycle.
  task automatic single(input string tag, input int p, input logic w,
                        input logic [AW-1:0] a, input logic [63:0] d,
                        input logic [7:0] b, input logic [63:0] exp);
    idle();
    setp(p, w, a, d, b);
    #1;
    check({tag, "_gnt"}, 64'(gnt1), 64'(1 << p));
    tick();
    idle();
    check({tag, "_rv"}, 64'(rv1), 64'(1 << p));
    check({tag, "_rd"}, rd1[p*DW +: DW], exp);
  endtask

  initial begin
    logic [1:0] prev;
    logic [1:0] eg;
    int c0;
    int c1;
    logic [63:0] ed;
    logic ev;

    idle();
    addr  = '0;
    wdata = '0;
    be    = '0;
    wuser = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rv", 64'({rv1, rv3}), 64'(0));
    check("rst_rd1", rd1[63:0] | rd1[127:64], 64'(0));
    check("rst_rd3", rd3[63:0] | rd3[127:64], 64'(0));
    check("rst_ru", 64'({ru1, ru3}), 64'(0));
    rst_n = 1'b1;
    tick();

    single("wr5", 0, 1'b1, 10'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'h0);
    single("rd5", 0, 1'b0, 10'd5, 64'h0, 8'h00, 64'hDEADBEEF_CAFEF00D);
    single("wr1", 1, 1'b1, 10'd1, 64'h1111_2222_3333_4444, 8'hFF, 64'h0);

    idle();
    tick();
    prev = 2'b00;
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 5; k++) begin
      check("cf_rv", 64'(rv1), 64'(prev));
      if (prev[0]) begin
        c0++;
        check("cf_rd0", rd1[63:0], 64'h1111_2222_3333_4444);
      end
      if (prev[1]) begin
        c1++;
        check("cf_rd1", rd1[127:64], 64'hDEADBEEF_CAFEF00D);
      end
      if (k < 4) begin
        setp(0, 1'b0, 10'd1, 64'h0, 8'h00);
        setp(1, 1'b0, 10'd5, 64'h0, 8'h00);
        #1;
        eg = (k % 2 == 0) ? 2'b01 : 2'b10;
        check("cf_gnt", 64'(gnt1), 64'(eg));
        prev = eg;
        tick();
      end else begin
        idle();
      end
    end
    check("cf_cnt0", 64'(c0), 64'(2));
    check("cf_cnt1", 64'(c1), 64'(2));

    single("wr0", 0, 1'b1, 10'd0, 64'h0A0A_0B0B_0C0C_0D0D, 8'hFF, 64'h0);
    idle();
    setp(0, 1'b0, 10'd0, 64'h0, 8'h00);
    setp(1, 1'b0, 10'd1, 64'h0, 8'h00);
    #1;
    check("par_gnt", 64'(gnt1), 64'(3));
    tick();
    idle();
    check("par_rv", 64'(rv1), 64'(3));
    check("par_rd0", rd1[63:0], 64'h0A0A_0B0B_0C0C_0D0D);
    check("par_rd1", rd1[127:64], 64'h1111_2222_3333_4444);

    single("be_ff", 0, 1'b1, 10'd8, '1, 8'hFF, 64'h0);
    single("be_0f", 0, 1'b1, 10'd8, 64'h0, 8'h0F, 64'h0);
    single("be_rd", 0, 1'b0, 10'd8, 64'h0, 8'h00, 64'hFFFFFFFF_00000000);
    single("be_00", 0, 1'b1, 10'd8, 64'h1234, 8'h00, 64'h0);
    single("be_rd2", 0, 1'b0, 10'd8, 64'h0, 8'h00, 64'hFFFFFFFF_00000000);

    for (int k = 0; k < 8; k++) begin
      single("l3_wr", 0, 1'b1, 10'(k), 64'h100 + 64'(k), 8'hFF, 64'h0);
    end
    idle();
    repeat (4) tick();
    for (int c = 0; c < 12; c++) begin
      ev = (c >= 3) && (c <= 10);
      ed = ev ? 64'h100 + 64'(c - 3) : 64'h0;
      check("l3_rv", 64'(rv3), 64'(ev));
      check("l3_rd", rd3[63:0], ed);
      if (c < 8) begin
        setp(0, 1'b0, 10'(c), 64'h0, 8'h00);
        #1;
        check("l3_gnt", 64'(gnt3), 64'(1));
      end else begin
        idle();
      end
      tick();
    end

    single("pre_rd1", 0, 1'b0, 10'd1, 64'h0, 8'h00, 64'h101);
    idle();
    setp(0, 1'b0, 10'd2, 64'h0, 8'h00);
    #1;
    check("rs_gnt", 64'(gnt3), 64'(1));
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("rs_rv", 64'(rv3), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("rs_rv_post", 64'(rv3), 64'(0));
      check("rs_rd_post", rd3[63:0] | rd3[127:64], 64'(0));
      tick();
    end
    setp(0, 1'b0, 10'd1, 64'h0, 8'h00);
    setp(1, 1'b0, 10'd5, 64'h0, 8'h00);
    #1;
    check("rs_rr_gnt0", 64'(gnt1), 64'(1));
    tick();
    check("rs_rr_rv0", 64'(rv1), 64'(1));
    check("rs_rr_rd0", rd1[63:0], 64'h101);
    #1;
    check("rs_rr_gnt1", 64'(gnt1), 64'(2));
    tick();
    idle();
    check("rs_rr_rv1", 64'(rv1), 64'(2));
    check("rs_rr_rd1", rd1[127:64], 64'h105);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
